// File: rtl/video_pkg.sv
// video_pkg: shared video types and constants for the pixel pipeline.
package video_pkg;
    localparam int COORD_W = 12;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;
    typedef logic [1:0] pal_idx_t;
    localparam pal_idx_t TRANSPARENT_IDX = 2'd0;
endpackage

// File: rtl/sprite_ram.sv
// sprite_ram: simple dual-port bitmap RAM, synchronous read, old data on collision.
module sprite_ram import video_pkg::*; #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  pal_idx_t      i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output pal_idx_t      o_rd_data
);
    pal_idx_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        o_rd_data <= r_mem[i_rd_addr];
    end
endmodule

// File: rtl/sprite_overlay.sv
// sprite_overlay: overlays one 2-bit-palette sprite onto a VGA stream with 2-clk latency.
// Optional SPRITE_MIRROR_EN adds the spr_mirror port for horizontal flipping.
module sprite_overlay import video_pkg::*; #(
    parameter int SPR_W   = 16,
    parameter int SPR_H   = 16,
    parameter int COORD_W = video_pkg::COORD_W,
    localparam int AW     = $clog2(SPR_W * SPR_H),
    localparam int XW     = $clog2(SPR_W),
    localparam int YW     = $clog2(SPR_H)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic               de_in,
    input  logic [7:0]         r_in,
    input  logic [7:0]         g_in,
    input  logic [7:0]         b_in,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               pos_valid,
    input  logic               spr_en,
`ifdef SPRITE_MIRROR_EN
    input  logic               spr_mirror,
`endif
    input  rgb_t               col1,
    input  rgb_t               col2,
    input  rgb_t               col3,
    input  logic               spr_wr_en,
    input  logic [AW-1:0]      spr_wr_addr,
    input  pal_idx_t           spr_wr_data,
    output logic               hs_out,
    output logic               vs_out,
    output logic               de_out,
    output logic [7:0]         r_out,
    output logic [7:0]         g_out,
    output logic [7:0]         b_out
);
    logic [COORD_W-1:0] r_x_cnt, r_y_cnt, r_pend_x, r_pend_y, r_act_x, r_act_y;
    logic               r_pend_en, r_act_en, r_pend_mir, r_act_mir, r_vs_prev, r_de_prev;
    logic               r_hit1, r_hs1, r_vs1, r_de1;
    rgb_t               r_rgb1;
    logic               w_mir_in, w_vs_fall, w_de_fall, w_hit;
    logic [COORD_W:0]   w_x_end, w_y_end;
    logic [XW-1:0]      w_dx, w_col;
    logic [YW-1:0]      w_dy;
    logic [AW-1:0]      w_rd_addr;
    pal_idx_t           w_idx;
    rgb_t               w_pal, w_pix;

`ifdef SPRITE_MIRROR_EN
    assign w_mir_in = spr_mirror;
`else
    assign w_mir_in = 1'b0;
`endif

    assign w_vs_fall = r_vs_prev & ~vs_in;
    assign w_de_fall = r_de_prev & ~de_in;

    // One extra bit on the end coordinates so right/bottom sprites clip instead of wrapping
    assign w_x_end   = {1'b0, r_act_x} + (COORD_W+1)'(SPR_W);
    assign w_y_end   = {1'b0, r_act_y} + (COORD_W+1)'(SPR_H);
    assign w_hit     = de_in & r_act_en & (r_x_cnt >= r_act_x) & ({1'b0, r_x_cnt} < w_x_end)
                     & (r_y_cnt >= r_act_y) & ({1'b0, r_y_cnt} < w_y_end);
    assign w_dx      = XW'(r_x_cnt - r_act_x);
    assign w_dy      = YW'(r_y_cnt - r_act_y);
    assign w_col     = w_dx ^ {XW{r_act_mir}};
    assign w_rd_addr = {w_dy, w_col};

    assign w_pal = (w_idx == 2'd1) ? col1 : (w_idx == 2'd2) ? col2 : col3;
    assign w_pix = (r_hit1 && w_idx != TRANSPARENT_IDX) ? w_pal : r_rgb1;

    sprite_ram #(.DEPTH(SPR_W * SPR_H)) u_ram (
        .clk      (clk),
        .i_wr_en  (spr_wr_en),
        .i_wr_addr(spr_wr_addr),
        .i_wr_data(spr_wr_data),
        .i_rd_addr(w_rd_addr),
        .o_rd_data(w_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x_cnt    <= '0;
            r_y_cnt    <= '0;
            r_vs_prev  <= 1'b1;
            r_de_prev  <= 1'b0;
            r_pend_x   <= '0;
            r_pend_y   <= '0;
            r_pend_en  <= 1'b0;
            r_pend_mir <= 1'b0;
            r_act_x    <= '0;
            r_act_y    <= '0;
            r_act_en   <= 1'b0;
            r_act_mir  <= 1'b0;
        end else begin
            r_vs_prev <= vs_in;
            r_de_prev <= de_in;
            r_x_cnt   <= de_in ? r_x_cnt + COORD_W'(1) : '0;
            r_y_cnt   <= w_vs_fall ? '0 : w_de_fall ? r_y_cnt + COORD_W'(1) : r_y_cnt;
            if (pos_valid) {r_pend_x, r_pend_y, r_pend_en, r_pend_mir} <= {pos_x, pos_y, spr_en, w_mir_in};
            if (w_vs_fall)
                {r_act_x, r_act_y, r_act_en, r_act_mir} <= pos_valid ? {pos_x, pos_y, spr_en, w_mir_in}
                                                                     : {r_pend_x, r_pend_y, r_pend_en, r_pend_mir};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {r_hit1, r_hs1, r_vs1, r_de1} <= 4'b0110;
            r_rgb1                        <= '0;
            {hs_out, vs_out, de_out}      <= 3'b110;
            {r_out, g_out, b_out}         <= '0;
        end else begin
            {r_hit1, r_hs1, r_vs1, r_de1} <= {w_hit, hs_in, vs_in, de_in};
            r_rgb1                        <= {r_in, g_in, b_in};
            {hs_out, vs_out, de_out}      <= {r_hs1, r_vs1, r_de1};
            {r_out, g_out, b_out}         <= r_de1 ? w_pix : '0;
        end
    end
endmodule

// File: tb/tb_sprite_overlay.sv
// tb_sprite_overlay: randomized stream against a pixel-level reference model of the overlay.
module tb_sprite_overlay;
    localparam int SW = 16, SH = 16, CW = 12, AW = 8;
    localparam int H_ACT = 40, H_TOT = 52, V_ACT = 30, V_TOT = 34;
    localparam int FR = V_TOT * H_TOT;
    localparam int VS_FALL = (V_ACT + 1) * H_TOT;
`ifdef SPRITE_MIRROR_EN
    localparam bit HAS_MIR = 1'b1;
`else
    localparam bit HAS_MIR = 1'b0;
`endif

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          hs_in = 1'b1, vs_in = 1'b1, de_in = 1'b0;
    logic [7:0]    r_in = '0, g_in = '0, b_in = '0;
    logic [CW-1:0] pos_x = '0, pos_y = '0;
    logic          pos_valid = 1'b0, spr_en = 1'b0, spr_mirror = 1'b0;
    logic [23:0]   col1 = '0, col2 = '0, col3 = '0;
    logic          spr_wr_en = 1'b0;
    logic [AW-1:0] spr_wr_addr = '0;
    logic [1:0]    spr_wr_data = '0;
    logic          hs_out, vs_out, de_out;
    logic [7:0]    r_out, g_out, b_out;

    always #5 clk = ~clk;

    sprite_overlay #(.SPR_W(SW), .SPR_H(SH), .COORD_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .pos_x(pos_x), .pos_y(pos_y),
        .pos_valid(pos_valid), .spr_en(spr_en),
`ifdef SPRITE_MIRROR_EN
        .spr_mirror(spr_mirror),
`endif
        .col1(col1), .col2(col2), .col3(col3), .spr_wr_en(spr_wr_en),
        .spr_wr_addr(spr_wr_addr), .spr_wr_data(spr_wr_data), .hs_out(hs_out),
        .vs_out(vs_out), .de_out(de_out), .r_out(r_out), .g_out(g_out), .b_out(b_out)
    );

    typedef struct {
        bit          hs, vs, de, hit;
        int          idx;
        logic [23:0] rgb;
    } ent_t;

    int          total = 0, bad = 0;
    logic [1:0]  mem [SW*SH];
    logic [23:0] pal [4];
    int          pend_x, pend_y, act_x, act_y, wq[$];
    bit          pend_en, pend_mir, act_en, act_mir, prev_vs;
    ent_t        e1;

    task automatic check(input string tag, input logic [26:0] got, input logic [26:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] fin(input ent_t e);
        logic [23:0] c;
        c = !e.de ? 24'h0 : (e.hit && e.idx != 0) ? pal[e.idx] : e.rgb;
        return {e.hs, e.vs, e.de, c};
    endfunction

    task automatic model_reset();
        pend_x = 0; pend_y = 0; pend_en = 0; pend_mir = 0;
        act_x = 0; act_y = 0; act_en = 0; act_mir = 0;
        prev_vs = 1;
        e1 = '{hs: 1, vs: 1, de: 0, hit: 0, idx: 0, rgb: 24'h0};
    endtask

    task automatic step(input int x, input int y, input bit hs, input bit vs, input bit de,
                        input bit pv, input int px, input int py, input bit en, input bit mir,
                        input string tag);
        ent_t        e0;
        logic [26:0] exp;
        int          dx, w, wa;
        bit          we;
        hs_in = hs; vs_in = vs; de_in = de;
        {r_in, g_in, b_in} = de ? 24'($urandom) : ($urandom_range(0, 1) ? 24'h123456 : 24'($urandom));
        pos_valid  = pv;
        pos_x      = pv ? CW'(px) : CW'($urandom);
        pos_y      = pv ? CW'(py) : CW'($urandom);
        spr_en     = pv ? en : 1'($urandom);
        spr_mirror = pv ? mir : 1'($urandom);
        we = wq.size() > 0;
        w  = we ? wq.pop_front() : 0;
        wa = w >> 2;
        spr_wr_en   = we;
        spr_wr_addr = we ? AW'(wa) : AW'($urandom);
        spr_wr_data = we ? w[1:0] : 2'($urandom);
        col1 = pal[1]; col2 = pal[2]; col3 = pal[3];
        e0.hs = hs; e0.vs = vs; e0.de = de; e0.rgb = {r_in, g_in, b_in};
        e0.hit = de && act_en && x >= act_x && x < act_x + SW && y >= act_y && y < act_y + SH;
        e0.idx = 0;
        if (e0.hit) begin
            dx = act_mir ? SW - 1 - (x - act_x) : x - act_x;
            e0.idx = int'(mem[(y - act_y) * SW + dx]);
        end
        exp = fin(e1);
        if (prev_vs && !vs) begin
            act_x   = pv ? px : pend_x;
            act_y   = pv ? py : pend_y;
            act_en  = pv ? en : pend_en;
            act_mir = pv ? (mir & HAS_MIR) : pend_mir;
        end
        if (pv) begin
            pend_x = px; pend_y = py; pend_en = en; pend_mir = mir & HAS_MIR;
        end
        prev_vs = vs;
        if (we) mem[wa] = w[1:0];
        e1 = e0;
        @(posedge clk);
        #1;
        check(tag, {hs_out, vs_out, de_out, r_out, g_out, b_out}, exp);
        @(negedge clk);
    endtask

    task automatic run_frame(input int pv_at, input int px, input int py, input bit en, input bit mir,
                             input int wr_pct, input int ncyc, input string tag);
        int ln, h;
        for (int c = 0; c < ncyc; c++) begin
            ln = c / H_TOT;
            h  = c % H_TOT;
            if (wr_pct > 0 && $urandom_range(0, 99) < wr_pct)
                wq.push_back(int'($urandom_range(0, SW*SH-1)) * 4 + int'($urandom_range(0, 3)));
            step(h, ln, !(h >= H_ACT + 2 && h < H_ACT + 6), !(ln >= V_ACT + 1 && ln < V_ACT + 3),
                 ln < V_ACT && h < H_ACT, c == pv_at, px, py, en, mir, tag);
        end
    endtask

    task automatic rand_pal();
        for (int i = 1; i < 4; i++) pal[i] = 24'($urandom);
    endtask

    initial begin
        for (int i = 0; i < SW*SH; i++) mem[i] = 2'd0;
        pal[0] = 24'h0;
        rand_pal();
        model_reset();
        repeat (3) @(negedge clk);
        check("reset", {hs_out, vs_out, de_out, r_out, g_out, b_out}, {3'b110, 24'h0});
        reset_n = 1'b1;
        for (int a = 0; a < SW*SH; a++) wq.push_back(a * 4 + (a == 0 ? 0 : 1));
        pal[1] = 24'hFF0000;
        run_frame(300, 10, 5, 1, 0, 0, FR, "pipe");
        run_frame(-1, 0, 0, 0, 0, 0, FR, "basic");
        run_frame(10 * H_TOT + 3, 20, 5, 1, 0, 0, FR, "latch_mid");
        run_frame(VS_FALL, 5, 12, 1, 0, 0, FR, "latch_next");
        run_frame(200, H_ACT - 8, V_ACT - 8, 1, 0, 0, FR, "latch_coinc");
        run_frame(200, 4090, 4092, 1, 0, 0, FR, "clip");
        for (int a = 0; a < SW*SH; a++) wq.push_back(a * 4 + ((a % SW) == 0 ? 2 : 0));
        pal[2] = 24'h00FF00;
        run_frame(1000, 0, 0, 1, 1, 0, FR, "wrap");
        run_frame(-1, 0, 0, 0, 0, 0, FR, "mirror");
        for (int i = 0; i < 5; i++) begin
            rand_pal();
            run_frame($urandom_range(0, FR - 1), $urandom_range(0, H_ACT), $urandom_range(0, V_ACT),
                      $urandom_range(0, 3) != 0, 1'($urandom), 5, FR, "rand");
        end
        run_frame(-1, 0, 0, 0, 0, 5, FR / 2, "rand");
        reset_n = 1'b0;
        hs_in = 1'b1; vs_in = 1'b1; de_in = 1'b0; pos_valid = 1'b0; spr_wr_en = 1'b0;
        #1;
        check("midrst", {hs_out, vs_out, de_out, r_out, g_out, b_out}, {3'b110, 24'h0});
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        run_frame(50, 7, 7, 1, 0, 5, FR, "post_rst");
        run_frame(-1, 0, 0, 0, 0, 5, FR, "post_rst2");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
